// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// mem_arbiter : ICACHE/DCACHE fill and DCACHE store arbiter for one memory port
// Optional macro MEM_ARB_DPRIO_EN: DCACHE miss wins ties against ICACHE miss.
// Revision: 1.0
// ============================================================================
module mem_arbiter #(
  parameter int BLOCK_WORDS = 8,
  parameter int ADDR_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_miss,
  input  logic [ADDR_W-1:0] i_miss_addr,
  input  logic              d_miss,
  input  logic [ADDR_W-1:0] d_miss_addr,
  input  logic              d_wr_req,
  input  logic [ADDR_W-1:0] d_wr_addr,
  input  logic [15:0]       d_wr_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_enable,
  output logic              mem_wr,
  output logic [15:0]       mem_data_in,
  input  logic [15:0]       mem_data_out,
  input  logic              mem_data_valid,
  output logic [15:0]       fill_data,
  output logic [ADDR_W-1:0] fill_addr,
  output logic              i_fill_we,
  output logic              d_fill_we,
  output logic              i_done,
  output logic              d_done,
  output logic              d_wr_ack,
  output logic              busy
);

  localparam int CW    = $clog2(BLOCK_WORDS) + 1;
  localparam int OFF_W = $clog2(2 * BLOCK_WORDS);
  localparam logic [CW-1:0] C_NWORDS = CW'(BLOCK_WORDS);
  localparam logic [CW-1:0] C_LAST   = CW'(BLOCK_WORDS - 1);
  localparam logic [CW-1:0] C_ONE    = CW'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_FILL  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t            r_state;
  logic              r_owner_d;
  logic [ADDR_W-1:0] r_base;
  logic [CW-1:0]     r_icnt;
  logic [CW-1:0]     r_rcnt;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_mem_en;
  logic              r_mem_wr;
  logic [15:0]       r_mem_wdata;
  logic              r_wr_ack;
  logic              r_i_done;
  logic              r_d_done;

  logic              w_any_miss;
  logic              w_grant_d;
  logic [ADDR_W-1:0] w_miss_addr;
  logic [ADDR_W-1:0] w_miss_base;
  logic [ADDR_W-1:0] w_issue_addr;
  logic [ADDR_W-1:0] w_ret_addr;
  logic              w_fill_v;

  assign w_any_miss = i_miss | d_miss;
`ifdef MEM_ARB_DPRIO_EN
  assign w_grant_d  = d_miss;
`else
  assign w_grant_d  = d_miss & ~i_miss;
`endif
  assign w_miss_addr  = w_grant_d ? d_miss_addr : i_miss_addr;
  assign w_miss_base  = {w_miss_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign w_issue_addr = r_base + {{(ADDR_W-CW-1){1'b0}}, r_icnt, 1'b0};
  assign w_ret_addr   = r_base + {{(ADDR_W-CW-1){1'b0}}, r_rcnt, 1'b0};
  assign w_fill_v     = (r_state == ST_FILL) & mem_data_valid;

  // Memory strobes are registered one step ahead, so r_icnt counts the next
  // word to issue; word 0 is launched directly by the grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_owner_d   <= 1'b0;
      r_base      <= '0;
      r_icnt      <= '0;
      r_rcnt      <= '0;
      r_mem_addr  <= '0;
      r_mem_en    <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_mem_wdata <= '0;
      r_wr_ack    <= 1'b0;
      r_i_done    <= 1'b0;
      r_d_done    <= 1'b0;
    end else begin
      r_wr_ack <= 1'b0;
      r_i_done <= 1'b0;
      r_d_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_mem_en    <= 1'b0;
          r_mem_wr    <= 1'b0;
          r_mem_wdata <= '0;
          r_mem_addr  <= '0;
          if (d_wr_req) begin
            r_state     <= ST_WRITE;
            r_mem_en    <= 1'b1;
            r_mem_wr    <= 1'b1;
            r_mem_addr  <= d_wr_addr;
            r_mem_wdata <= d_wr_data;
            r_wr_ack    <= 1'b1;
          end else if (w_any_miss) begin
            r_state    <= ST_FILL;
            r_owner_d  <= w_grant_d;
            r_base     <= w_miss_base;
            r_mem_en   <= 1'b1;
            r_mem_addr <= w_miss_base;
            r_icnt     <= C_ONE;
            r_rcnt     <= '0;
          end
        end
        ST_WRITE: begin
          r_state     <= ST_IDLE;
          r_mem_en    <= 1'b0;
          r_mem_wr    <= 1'b0;
          r_mem_wdata <= '0;
          r_mem_addr  <= '0;
        end
        ST_FILL: begin
          if (r_icnt < C_NWORDS) begin
            r_mem_addr <= w_issue_addr;
            r_icnt     <= r_icnt + C_ONE;
          end else begin
            r_mem_en   <= 1'b0;
            r_mem_addr <= '0;
          end
          if (mem_data_valid) begin
            r_rcnt <= r_rcnt + C_ONE;
            if (r_rcnt == C_LAST) begin
              r_state    <= ST_DONE;
              r_mem_en   <= 1'b0;
              r_mem_addr <= '0;
              r_i_done   <= ~r_owner_d;
              r_d_done   <= r_owner_d;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem_addr    = r_mem_addr;
  assign mem_enable  = r_mem_en;
  assign mem_wr      = r_mem_wr;
  assign mem_data_in = r_mem_wdata;
  assign fill_data   = w_fill_v ? mem_data_out : 16'h0000;
  assign fill_addr   = w_fill_v ? w_ret_addr : '0;
  assign i_fill_we   = w_fill_v & ~r_owner_d;
  assign d_fill_we   = w_fill_v & r_owner_d;
  assign i_done      = r_i_done;
  assign d_done      = r_d_done;
  assign d_wr_ack    = r_wr_ack;
  assign busy        = (r_state != ST_IDLE);

endmodule
`default_nettype wire
